register_4bit: RTL and testbench



---
 rtl/register_4bit.sv | 58 +++++
 tb/tb_register_4bit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/register_4bit.sv
`default_nettype none
// ============================================================================
// Module      : register_4bit
// Description : Universal register with clear, load, inc/dec and serial shifts,
//               one operation per edge chosen by fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module register_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cl,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             ir,
  input  logic             sl,
  input  logic             il,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // Earlier branches win; later requests in the same cycle are dropped.
  always_comb begin
    w_next = r_q;
    if (cl)
      w_next = c_zero;
    else if (ld)
      w_next = in;
    else if (inc)
      w_next = r_q + c_one;
    else if (dec)
      w_next = r_q - c_one;
    else if (sr)
      w_next = {ir, r_q[WIDTH-1:1]};
    else if (sl)
      w_next = {r_q[WIDTH-2:0], il};
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_q <= c_zero;
    else
      r_q <= w_next;
  end

  assign out = r_q;

endmodule
`default_nettype wire

// File: tb/tb_register_4bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_4bit
// Description : Directed and randomized self-checking bench for register_4bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_4bit;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst, cl, ld, inc, dec, sr, ir, sl, il;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  register_4bit #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .cl  (cl),
    .ld  (ld),
    .in  (in),
    .inc (inc),
    .dec (dec),
    .sr  (sr),
    .ir  (ir),
    .sl  (sl),
    .il  (il),
    .out (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Drive one set of controls, clock once, then settle 1 time unit past the edge.
  task automatic apply(input logic a_rst, input logic a_cl, input logic a_ld,
                       input logic [WIDTH-1:0] a_in, input logic a_inc,
                       input logic a_dec, input logic a_sr, input logic a_ir,
                       input logic a_sl, input logic a_il);
    rst = a_rst; cl = a_cl; ld = a_ld; in = a_in; inc = a_inc;
    dec = a_dec; sr = a_sr; ir = a_ir; sl = a_sl; il = a_il;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    apply(0, 0, 1, v, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input logic [WIDTH-1:0] v_in, input logic v_ir, input logic v_il);
    apply(0, 0, 0, v_in, 0, 0, 0, v_ir, 0, v_il);
  endtask

  logic [WIDTH-1:0] model_q;
  logic [9:0]       rnd;

  initial begin
    rst = 1; cl = 0; ld = 0; in = '0; inc = 0; dec = 0;
    sr = 0; ir = 0; sl = 0; il = 0;
    @(negedge clk);

    // Reset beats a pending load
    apply(1, 0, 1, 4'hA, 0, 0, 0, 0, 0, 0);
    check("reset_edge1", out, 4'h0);
    apply(1, 0, 1, 4'hA, 0, 0, 0, 0, 0, 0);
    check("reset_edge2", out, 4'h0);
    load(4'hA);
    check("reset_release_load", out, 4'hA);

    // Priority
    load(4'h5);
    check("load_5", out, 4'h5);
    apply(0, 1, 1, 4'h9, 1, 1, 1, 1, 1, 1);
    check("prio_clear_wins", out, 4'h0);
    load(4'h5);
    apply(0, 0, 1, 4'h9, 1, 0, 1, 0, 0, 0);
    check("prio_load_wins", out, 4'h9);
    apply(0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 0);
    check("prio_inc_over_dec", out, 4'hA);
    apply(0, 0, 0, 4'h0, 0, 0, 1, 1, 1, 0);
    check("prio_sr_over_sl", out, 4'hD);

    // Wrap-around
    load(4'hF);
    apply(0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    check("inc_wrap", out, 4'h0);
    apply(0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0);
    check("dec_wrap", out, 4'hF);

    // Shifts
    load(4'b1001);
    apply(0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0);
    check("sr_ir0", out, 4'b0100);
    apply(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 1);
    check("sl_il1", out, 4'b1001);
    apply(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0);
    check("sl_il0", out, 4'b0010);
    apply(0, 0, 0, 4'h0, 0, 0, 1, 1, 0, 0);
    check("sr_ir1", out, 4'b1001);

    // Hold with data inputs toggling
    load(4'h6);
    idle(4'hF, 1, 1);
    check("hold_1", out, 4'h6);
    idle(4'h0, 0, 0);
    check("hold_2", out, 4'h6);
    idle(4'hA, 1, 0);
    check("hold_3", out, 4'h6);

    // Reset mid-sequence aborts an increment
    apply(1, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0);
    check("reset_mid", out, 4'h0);

    // Randomized controls against a priority reference model
    model_q = 4'h0;
    for (int i = 0; i < 1000; i++) begin
      rnd = 10'($urandom);
      in  = 4'($urandom);
      rst = ($urandom_range(0, 31) == 0);
      cl  = ($urandom_range(0, 15) == 0);
      ld  = rnd[0] & rnd[1];
      inc = rnd[2];
      dec = rnd[3];
      sr  = rnd[4];
      ir  = rnd[5];
      sl  = rnd[6];
      il  = rnd[7];
      if (rst || cl)  model_q = 4'h0;
      else if (ld)    model_q = in;
      else if (inc)   model_q = model_q + 4'h1;
      else if (dec)   model_q = model_q - 4'h1;
      else if (sr)    model_q = {ir, model_q[3:1]};
      else if (sl)    model_q = {model_q[2:0], il};
      @(posedge clk);
      #1;
      check("random", out, model_q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
